// File: rtl/rock_sequencer.sv
// Cradle rocking sequencer: drives a motor in half-swings whose length and duty
// follow frequency F and amplitude A; crying raises F, calm swings decay F then A.
module rock_sequencer #(
  parameter int CLK_DIV     = 1000,
  parameter int CALM_SWINGS = 4,
  parameter int F_INIT      = 5,
  parameter int A_INIT      = 5,
  parameter int F_MAX       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       cry,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [3:0] A,
  output logic [3:0] F,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state_o
);

  localparam int CW = $clog2(16 * CLK_DIV + 1);
  localparam int KW = (CALM_SWINGS > 1) ? $clog2(CALM_SWINGS) : 1;
  localparam logic [3:0]    F_INIT_V  = 4'(F_INIT);
  localparam logic [3:0]    A_INIT_V  = 4'(A_INIT);
  localparam logic [3:0]    F_MAX_V   = 4'(F_MAX);
  localparam logic [KW-1:0] CALM_LAST = KW'(CALM_SWINGS - 1);

  typedef enum logic [1:0] {IDLE, SWING, ADJUST, FINISH} state_t;

  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [KW-1:0] calm_q;
  logic          cry_seen_q;
  logic [3:0]    a_q, f_q;
  logic          motor_en_q, motor_dir_q, busy_q, done_q;

  function automatic logic [CW-1:0] half_len(input logic [3:0] f);
    logic [4:0] span;
    span = 5'd16 - {1'b0, f};
    half_len = CW'(int'(span) * CLK_DIV);
  endfunction

  // Motor drive window: min(A, 16-F) timing units from the start of a half-swing.
  function automatic logic [CW-1:0] on_len(input logic [3:0] a, input logic [3:0] f);
    logic [4:0] span, m;
    span = 5'd16 - {1'b0, f};
    m = ({1'b0, a} < span) ? {1'b0, a} : span;
    on_len = CW'(int'(m) * CLK_DIV);
  endfunction

  logic [CW-1:0] len_cur, on_cur, on_adj;
  logic [3:0]    a_adj_d, f_adj_d;
  logic [KW-1:0] calm_adj_d;

  always_comb begin
    len_cur    = half_len(f_q);
    on_cur     = on_len(a_q, f_q);
    a_adj_d    = a_q;
    f_adj_d    = f_q;
    calm_adj_d = calm_q;
    if (cry_seen_q) begin
      f_adj_d    = (f_q < F_MAX_V) ? f_q + 4'd1 : F_MAX_V;
      a_adj_d    = A_INIT_V;
      calm_adj_d = '0;
    end else if (calm_q == CALM_LAST) begin
      calm_adj_d = '0;
      if (f_q != 4'd0)      f_adj_d = f_q - 4'd1;
      else if (a_q != 4'd0) a_adj_d = a_q - 4'd1;
    end else begin
      calm_adj_d = calm_q + KW'(1);
    end
    on_adj = on_len(a_adj_d, f_adj_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      calm_q      <= '0;
      cry_seen_q  <= 1'b0;
      a_q         <= A_INIT_V;
      f_q         <= F_INIT_V;
      motor_en_q  <= 1'b0;
      motor_dir_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q     <= 1'b0;
          motor_en_q <= 1'b0;
          busy_q     <= 1'b0;
          if (start) begin
            state_q    <= SWING;
            a_q        <= A_INIT_V;
            f_q        <= F_INIT_V;
            calm_q     <= '0;
            cry_seen_q <= 1'b0;
            cyc_q      <= '0;
            busy_q     <= 1'b1;
            motor_en_q <= (on_len(A_INIT_V, F_INIT_V) != '0);
          end
        end
        SWING: begin
          if (stop) begin
            state_q    <= IDLE;
            motor_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            cry_seen_q <= cry_seen_q | cry;
            if (cyc_q == len_cur - CW'(1)) begin
              state_q     <= ADJUST;
              motor_en_q  <= 1'b0;
              motor_dir_q <= ~motor_dir_q;
            end else begin
              cyc_q      <= cyc_q + CW'(1);
              motor_en_q <= ((cyc_q + CW'(1)) < on_cur);
            end
          end
        end
        ADJUST: begin
          if (stop) begin
            state_q    <= IDLE;
            motor_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            a_q        <= a_adj_d;
            f_q        <= f_adj_d;
            calm_q     <= calm_adj_d;
            cry_seen_q <= 1'b0;
            cyc_q      <= '0;
            if (a_adj_d == 4'd0 && f_adj_d == 4'd0) begin
              state_q    <= FINISH;
              motor_en_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= SWING;
              motor_en_q <= (on_adj != '0);
            end
          end
        end
        FINISH: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          motor_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign motor_en    = motor_en_q;
  assign motor_dir   = motor_dir_q;
  assign A           = a_q;
  assign F           = f_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rock_sequencer.sv
// Bench for rock_sequencer: swing-position model checked every cycle, plus
// directed sessions with hand-derived timing and value expectations.
module tb_rock_sequencer;

  localparam int CLK_DIV = 2;
  localparam int CALM    = 2;
  localparam int F_INIT  = 5;
  localparam int A_INIT  = 5;
  localparam int F_MAX   = 15;

  logic       clk = 1'b0;
  logic       reset, start, stop, cry;
  logic       motor_en, motor_dir, busy, done;
  logic [3:0] A, F;
  logic [1:0] dbg_state;

  rock_sequencer #(
    .CLK_DIV(CLK_DIV), .CALM_SWINGS(CALM), .F_INIT(F_INIT), .A_INIT(A_INIT), .F_MAX(F_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cry(cry),
    .motor_en(motor_en), .motor_dir(motor_dir), .A(A), .F(F),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // Model: t is the position inside the current swing; t == L is the one-cycle pause.
  typedef struct {
    int a, f, calm, t;
    bit cs, act, fin, dir;
  } mstate_t;

  mstate_t m = '{a: A_INIT, f: F_INIT, calm: 0, t: 0, cs: 0, act: 0, fin: 0, dir: 0};

  function automatic int m_len(int f);
    return (16 - f) * CLK_DIV;
  endfunction

  function automatic int m_on(int a, int f);
    return ((a < 16 - f) ? a : 16 - f) * CLK_DIV;
  endfunction

  function automatic mstate_t m_next(mstate_t s, bit rst, bit st, bit sp, bit cr);
    mstate_t n;
    n = s;
    if (rst) begin
      n = '{a: A_INIT, f: F_INIT, calm: 0, t: 0, cs: 0, act: 0, fin: 0, dir: 0};
    end else if (s.fin) begin
      n.fin = 0;
    end else if (!s.act) begin
      if (st) begin
        n.act = 1; n.a = A_INIT; n.f = F_INIT; n.calm = 0; n.cs = 0; n.t = 0;
      end
    end else if (sp) begin
      n.act = 0;
    end else if (s.t < m_len(s.f)) begin
      n.cs = s.cs | cr;
      n.t  = s.t + 1;
      if (n.t == m_len(s.f)) n.dir = ~s.dir;
    end else begin
      if (s.cs) begin
        n.f = (s.f + 1 > F_MAX) ? F_MAX : s.f + 1;
        n.a = A_INIT;
        n.calm = 0;
      end else if (s.calm == CALM - 1) begin
        n.calm = 0;
        if (s.f > 0) n.f = s.f - 1;
        else if (s.a > 0) n.a = s.a - 1;
      end else begin
        n.calm = s.calm + 1;
      end
      n.cs = 0;
      n.t  = 0;
      if (n.f == 0 && n.a == 0) begin
        n.act = 0;
        n.fin = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= m_next(m, reset, start, stop, cry);

  always @(negedge clk) begin
    logic [11:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {m.act && (m.t < m_on(m.a, m.f)), m.dir, 4'(m.a), 4'(m.f), m.act, m.fin};
      act_v = {motor_en, motor_dir, A, F, busy, done};
      checks++;
      if (exp_v === act_v) passes++;
      else $display("FAIL model_cycle t=%0t: got en/dir/A/F/busy/done=%03h expected %03h",
                    $time, act_v, exp_v);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int en_cnt, first_low, done_k, done_cnt;
    bit prev_busy;
    reset = 1'b1; start = 1'b0; stop = 1'b0; cry = 1'b0;
    step(); step();
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset then idle
    repeat (10) step();
    check("idle_A", A, 5);
    check("idle_F", F, 5);
    check("idle_en", motor_en, 0);
    check("idle_dir", motor_dir, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Calm session from start to the done pulse; k counts samples after the start edge
    pulse_start();
    en_cnt = 0; first_low = -1; done_k = -1; done_cnt = 0; prev_busy = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (k < 22) begin
        if (motor_en) en_cnt++;
        else if (first_low < 0) first_low = k;
      end
      if (k == 22) begin
        check("adj1_en", motor_en, 0);
        check("adj1_dir", motor_dir, 1);
        check("adj1_busy", busy, 1);
        check("adj1_state", dbg_state, 2);
      end
      if (k == 23) check("swing2_F", F, 5);
      if (k == 46) begin
        check("adj2_F", F, 4);
        check("adj2_A", A, 5);
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          check("done_busy", busy, 0);
          check("done_prev_busy", prev_busy, 1);
          check("done_A", A, 0);
          check("done_F", F, 0);
        end
      end
      if (done_k >= 0 && k >= done_k + 5) break;
      prev_busy = busy;
      step();
    end
    check("swing1_en_cycles", en_cnt, 10);
    check("swing1_en_first_low", first_low, 10);
    check("done_cycle", done_k, 600);
    check("done_pulses", done_cnt, 1);

    // One cry cycle in swing 1, then continuous crying to saturation
    pulse_start();
    repeat (3) step();
    cry = 1'b1;
    step();
    cry = 1'b0;
    repeat (19) step();
    check("cry_adj_F", F, 6);
    check("cry_adj_A", A, 5);
    cry = 1'b1;
    repeat (300) step();
    check("sat_F", F, 15);
    check("sat_A", A, 5);
    check("sat_busy", busy, 1);
    cry = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_sat_busy", busy, 0);
    check("stop_sat_F_hold", F, 15);

    // Restart, stray start mid-session, stop mid-swing
    pulse_start();
    check("restart_A", A, 5);
    check("restart_F", F, 5);
    repeat (8) step();
    pulse_start();
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_swing_busy", busy, 0);
    check("stop_swing_en", motor_en, 0);
    check("stop_swing_done", done, 0);
    repeat (4) step();

    // Stop during the pause wins over the pending cry update
    pulse_start();
    repeat (3) step();
    cry = 1'b1;
    step();
    cry = 1'b0;
    repeat (18) step();
    check("stop_adj_state", dbg_state, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_adj_F", F, 5);
    check("stop_adj_busy", busy, 0);
    repeat (4) step();

    // Reset during the pause alongside cry and stop
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse_start();
    repeat (3) step();
    cry = 1'b1;
    step();
    cry = 1'b0;
    repeat (18) step();
    check("rst_pre_dir", motor_dir, 1);
    reset = 1'b1; cry = 1'b1; stop = 1'b1;
    step();
    reset = 1'b0; cry = 1'b0; stop = 1'b0;
    check("rst_F", F, 5);
    check("rst_A", A, 5);
    check("rst_dir", motor_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_en", motor_en, 0);
    check("rst_done", done, 0);
    repeat (5) step();
    check("rst_after_done", done, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rock_sequencer.md
ROCK_SEQUENCER -- requirements
Module: rock_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_DIV, 1000, clock cycles per timing unit
- CALM_SWINGS, 4, consecutive calm swings before one decay step (>=1)
- F_INIT, 5, frequency value at start and reset
- A_INIT, 5, amplitude value at start, reset and cry restore
- F_MAX, 15, frequency saturation ceiling (<=15)
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begin rocking session
- stop  in  1  abort session
- cry  in  1  baby-crying level, already synchronous to clk
- motor_en  out  1  drive motor this cycle
- motor_dir  out  1  swing direction
- A  out  4  current amplitude
- F  out  4  current frequency
- busy  out  1  session active
- done  out  1  one-cycle pulse, session ended by decay to zero

Function
REQ-003 FSM states SHALL be IDLE, SWING, ADJUST, FINISH; all outputs registered.
REQ-004 IDLE: motor_en=0, busy=0; start=1 -> A=A_INIT, F=F_INIT, calm_cnt=0, cry_seen=0, cyc=0, state SWING next cycle.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 Half-swing length L SHALL be (16-F)*CLK_DIV cycles, computed with enough width for 16*CLK_DIV; F=0 -> 16*CLK_DIV.
REQ-007 SWING: cyc counts 0..L-1; motor_en=1 while cyc < min(A,16-F)*CLK_DIV, else 0; A=0 -> motor_en stays 0.
REQ-008 SWING: cry=1 on any cycle SHALL set sticky cry_seen.
REQ-009 SWING at cyc=L-1 -> ADJUST; ADJUST lasts exactly one cycle with motor_en=0, so one swing = L+1 cycles.
REQ-010 On entering ADJUST, motor_dir SHALL toggle.
REQ-011 ADJUST with cry_seen=1: F=min(F+1,F_MAX), A=A_INIT, calm_cnt=0.
REQ-012 ADJUST with cry_seen=0: if calm_cnt=CALM_SWINGS-1 then calm_cnt=0 and decay step (F>0: F-1; F=0 and A>0: A-1); else calm_cnt+1.
REQ-013 ADJUST SHALL clear cry_seen and cyc.
REQ-014 After ADJUST: updated F=0 and A=0 -> FINISH, else SWING.
REQ-015 FINISH: done=1, motor_en=0, busy=0 for one cycle -> IDLE; A, F hold 0.
REQ-016 busy=1 exactly in SWING and ADJUST.
REQ-017 stop=1 in SWING/ADJUST -> IDLE next cycle, motor_en=0, done=0, A/F hold; stop has priority over all ADJUST updates; stop ignored in IDLE/FINISH.
REQ-018 A and F SHALL never wrap: no increment beyond F_MAX, no decrement below 0.

Reset
REQ-019 reset=1 at rising edge SHALL override everything: state IDLE, A=A_INIT, F=F_INIT, motor_en=0, motor_dir=0, busy=0, done=0, calm_cnt=0, cry_seen=0, cyc=0.
REQ-020 reset mid-session SHALL abort with no done pulse.

Verification (CLK_DIV=2, CALM_SWINGS=2, defaults otherwise)
REQ-021 Reset then idle 10 cycles -> A=5, F=5, motor_en=0, motor_dir=0, busy=0, done=0.
REQ-022 start, cry=0 -> first SWING 22 cycles, motor_en high first 10, ADJUST 1 cycle, motor_dir=1; after 2nd ADJUST F=4, A=5.
REQ-023 start, cry=0 throughout -> F decays 5->0 then A 5->0 every 2 swings; one done pulse; busy falls same cycle done rises.
REQ-024 cry=1 one cycle in swing 1 -> ADJUST gives F=6, A=5, calm_cnt=0; cry every swing from F=14 -> F saturates at 15.
REQ-025 stop mid-SWING -> next cycle IDLE, motor_en=0, busy=0, done=0; later start restarts A=5, F=5.
REQ-026 reset asserted in ADJUST concurrent with cry=1 and stop=1 -> reset values of REQ-019 next cycle, no done.
